// File: rtl/uart_byte_receiver_pkg.sv
// Shared definitions for the 8N1 UART byte receiver: frame geometry and FSM state encodings.
package uart_byte_receiver_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_byte_receiver_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable reset level.
module uart_byte_receiver_sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver: mid-bit sampling of the synchronized rx line, one-cycle data/error strobes.
module uart_byte_receiver
  import uart_byte_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                      uart_clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data_receive,
  output logic                      data_valid,
  output logic                      frame_error,
  output logic                      rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(UART_DATA_BITS - 1);

  rx_state_e                 state_q, state_d;
  logic [CNT_W-1:0]          cycleCnt_q, cycleCnt_d;
  logic [BIT_W-1:0]          bitCnt_q, bitCnt_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] dataReceive_q, dataReceive_d;
  logic                      dataValid_q, dataValid_d;
  logic                      frameError_q, frameError_d;
  logic                      rxSync;

  uart_byte_receiver_sync_2ff #(
    .RESET_VALUE(1'b1)
  ) u_sync (
    .clk_i(uart_clk),
    .rst_i(rst),
    .d_i  (rx),
    .q_o  (rxSync)
  );

  // The counter restarts on every state change, so START waits half a bit and
  // DATA/STOP then land every full bit later, i.e. at mid-bit.
  always_comb begin
    state_d       = state_q;
    cycleCnt_d    = cycleCnt_q;
    bitCnt_d      = bitCnt_q;
    shift_d       = shift_q;
    dataReceive_d = dataReceive_q;
    dataValid_d   = 1'b0;
    frameError_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cycleCnt_d = '0;
        bitCnt_d   = '0;
        if (!rxSync) state_d = ST_START;
      end
      ST_START: begin
        if (cycleCnt_q == HALF_LAST) begin
          cycleCnt_d = '0;
          state_d    = rxSync ? ST_IDLE : ST_DATA;
        end else begin
          cycleCnt_d = cycleCnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cycleCnt_q == BIT_LAST) begin
          cycleCnt_d = '0;
          shift_d    = {rxSync, shift_q[UART_DATA_BITS-1:1]};
          if (bitCnt_q == LAST_BIT) begin
            bitCnt_d = '0;
            state_d  = ST_STOP;
          end else begin
            bitCnt_d = bitCnt_q + BIT_W'(1);
          end
        end else begin
          cycleCnt_d = cycleCnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cycleCnt_q == BIT_LAST) begin
          cycleCnt_d = '0;
          if (rxSync) begin
            dataReceive_d = shift_q;
            dataValid_d   = 1'b1;
            state_d       = ST_IDLE;
          end else begin
            frameError_d = 1'b1;
            state_d      = ST_BREAK;
          end
        end else begin
          cycleCnt_d = cycleCnt_q + CNT_W'(1);
        end
      end
      ST_BREAK: begin
        cycleCnt_d = '0;
        if (rxSync) state_d = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        cycleCnt_d = '0;
        bitCnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge uart_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cycleCnt_q <= '0;
      bitCnt_q   <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      cycleCnt_q <= cycleCnt_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
    end
  end

  always_ff @(posedge uart_clk) begin
    if (rst) begin
      dataReceive_q <= '0;
      dataValid_q   <= 1'b0;
      frameError_q  <= 1'b0;
    end else begin
      dataReceive_q <= dataReceive_d;
      dataValid_q   <= dataValid_d;
      frameError_q  <= frameError_d;
    end
  end

  assign data_receive = dataReceive_q;
  assign data_valid   = dataValid_q;
  assign frame_error  = frameError_q;
  assign rx_busy      = (state_q != ST_IDLE);

endmodule
